// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS fetch-stage control logic.
//   seq_state_e : pc_sequencer states (BOOT, FETCH, HALT)
//   pc_src_e    : next-PC source, ordered so that a larger value means a
//                 higher priority (SEQ < BR < JMP < EXC)
//   redirect_t  : one pending redirect (source + target address)
//   DEF_RESET_VECTOR / DEF_EXC_VECTOR : default boot and exception addresses
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        SRC_SEQ = 2'd0,
        SRC_BR  = 2'd1,
        SRC_JMP = 2'd2,
        SRC_EXC = 2'd3
    } pc_src_e;

    typedef struct packed {
        pc_src_e     src;
        logic [31:0] target;
    } redirect_t;

    localparam redirect_t NO_REDIRECT = '{src: SRC_SEQ, target: 32'h0};

endpackage

// File: rtl/next_pc_mux.sv
// ---------------------------------------------------------------------------
// next_pc_mux
// Pure priority select of the next program counter:
//   exception > jump > branch > sequential (pc + 4).
// Ports:
//   i_exc                     exception request (target is EXC_VECTOR)
//   i_jump,   i_jump_target   jump request and target
//   i_branch, i_branch_target taken-branch request and target
//   i_pc                      current PC, base for the sequential address
//   o_src                     winning source
//   o_target                  winning target address
// ---------------------------------------------------------------------------
module next_pc_mux
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        i_exc,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_branch,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_pc,
    output pc_src_e     o_src,
    output logic [31:0] o_target
);

    always_comb begin
        // NOTE: every output gets a default before the if-chain, so no path
        // leaves a value unassigned and no latch is inferred.
        o_src    = SRC_SEQ;
        o_target = i_pc + 32'd4;   // 32-bit add, wraps past 0xFFFF_FFFC
        if (i_exc) begin
            o_src    = SRC_EXC;
            o_target = EXC_VECTOR;
        end else if (i_jump) begin
            o_src    = SRC_JMP;
            o_target = i_jump_target;
        end else if (i_branch) begin
            o_src    = SRC_BR;
            o_target = i_branch_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Fetch-stage controller driving the PC register and the instruction-memory
// request handshake. States: BOOT (load RESET_VECTOR), FETCH (request until
// ack), HALT (debug halt, single-step via step_i).
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   pc_i                           current PC (PC register output)
//   pc_next_o, pc_en_o             PC register input and load enable
//   imem_req_o, imem_ack_i         fetch handshake, address is pc_i
//   fetch_valid_o                  fetched word valid for decode
//   stall_i                        hold PC and refetch
//   branch_i/branch_target_i       taken-branch redirect pulse
//   jump_i/jump_target_i           jump redirect pulse
//   exc_i/exc_pc_i                 exception pulse and faulting PC
//   epc_o, epc_we_o                saved exception PC and write pulse
//   halt_i, step_i, halted_o       debug halt level, step pulse, status
// ---------------------------------------------------------------------------
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        pc_en_o,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    output logic        fetch_valid_o,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        exc_i,
    input  logic [31:0] exc_pc_i,
    output logic [31:0] epc_o,
    output logic        epc_we_o,
    input  logic        halt_i,
    input  logic        step_i,
    output logic        halted_o
);

    seq_state_e  r_state;
    redirect_t   r_pend;
    logic [31:0] r_epc;
    logic        r_epc_we;

    logic        w_exc;
    logic        w_jump;
    logic        w_branch;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_branch_tgt;
    pc_src_e     w_src;
    logic [31:0] w_target;
    logic        w_redirect;
    logic        w_complete;

    // Merge the pending redirect with this cycle's pulses. A same-cycle
    // pulse of the same kind supplies the newer target.
    assign w_exc        = exc_i    || (r_pend.src == SRC_EXC);
    assign w_jump       = jump_i   || (r_pend.src == SRC_JMP);
    assign w_branch     = branch_i || (r_pend.src == SRC_BR);
    assign w_jump_tgt   = jump_i   ? jump_target_i   : r_pend.target;
    assign w_branch_tgt = branch_i ? branch_target_i : r_pend.target;

    next_pc_mux #(
        .EXC_VECTOR      (EXC_VECTOR)
    ) u_next_pc_mux (
        .i_exc           (w_exc),
        .i_jump          (w_jump),
        .i_jump_target   (w_jump_tgt),
        .i_branch        (w_branch),
        .i_branch_target (w_branch_tgt),
        .i_pc            (pc_i),
        .o_src           (w_src),
        .o_target        (w_target)
    );

    assign w_redirect = (w_src != SRC_SEQ);
    assign w_complete = (r_state == ST_FETCH) && imem_ack_i;

    always_comb begin
        pc_en_o       = 1'b0;
        pc_next_o     = w_target;
        fetch_valid_o = 1'b0;
        if (r_state == ST_BOOT) begin
            // Gated by rst_n so the PC register is not loaded while reset
            // is still held.
            pc_en_o   = rst_n;
            pc_next_o = RESET_VECTOR;
        end else if (w_complete) begin
            if (w_redirect) begin
                pc_en_o = 1'b1;               // squash, redirect wins over stall
            end else if (!stall_i) begin
                pc_en_o       = 1'b1;
                fetch_valid_o = 1'b1;
            end
        end
    end

    assign imem_req_o = (r_state == ST_FETCH);
    assign halted_o   = (r_state == ST_HALT);
    assign epc_o      = r_epc;
    assign epc_we_o   = r_epc_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_BOOT;
            r_pend   <= NO_REDIRECT;
            r_epc    <= 32'h0;
            r_epc_we <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples the pre-edge values regardless of statement order.
            r_epc_we <= exc_i;
            if (exc_i) begin
                r_epc <= exc_pc_i;
            end

            // The merged redirect is already the highest-priority one, so
            // storing it implements "replace only if equal or higher".
            if (w_complete) begin
                r_pend <= NO_REDIRECT;
            end else if (w_redirect) begin
                r_pend <= '{src: w_src, target: w_target};
            end

            case (r_state)
                ST_BOOT:  r_state <= ST_FETCH;
                ST_FETCH: if (w_complete && halt_i) r_state <= ST_HALT;
                ST_HALT:  if (step_i || !halt_i)    r_state <= ST_FETCH;
                default:  r_state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. The bench owns the PC register
// (loaded from pc_next_o when pc_en_o is high) and a behavioural model that
// tracks mode, pending redirect rank, expected PC and EPC. Inputs change
// 1 ns after the rising edge; outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'h0000_0080;
    localparam logic [31:0] PC_JUNK      = 32'hDEAD_BEE0;

    localparam int MODE_BOOT  = 0;
    localparam int MODE_FETCH = 1;
    localparam int MODE_HALT  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic [31:0] pc_next_o;
    logic        pc_en_o;
    logic        imem_req_o;
    logic        imem_ack_i;
    logic        fetch_valid_o;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        exc_i;
    logic [31:0] exc_pc_i;
    logic [31:0] epc_o;
    logic        epc_we_o;
    logic        halt_i;
    logic        step_i;
    logic        halted_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_mode;
    int          m_pend_rank;   // 0 none, 1 branch, 2 jump, 3 exception
    logic [31:0] m_pend_tgt;
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_epc_we;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_VECTOR    (RESET_VECTOR),
        .EXC_VECTOR      (EXC_VECTOR)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_i            (pc_i),
        .pc_next_o       (pc_next_o),
        .pc_en_o         (pc_en_o),
        .imem_req_o      (imem_req_o),
        .imem_ack_i      (imem_ack_i),
        .fetch_valid_o   (fetch_valid_o),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .exc_i           (exc_i),
        .exc_pc_i        (exc_pc_i),
        .epc_o           (epc_o),
        .epc_we_o        (epc_we_o),
        .halt_i          (halt_i),
        .step_i          (step_i),
        .halted_o        (halted_o)
    );

    // PC register of the surrounding pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pc_i <= PC_JUNK;
        else if (pc_en_o) pc_i <= pc_next_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        return $urandom() & 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        m_mode      = MODE_BOOT;
        m_pend_rank = 0;
        m_pend_tgt  = 32'h0;
        m_pc        = PC_JUNK;
        m_epc       = 32'h0;
        m_epc_we    = 1'b0;
    endtask

    task automatic clear_pulses();
        branch_i = 1'b0;
        jump_i   = 1'b0;
        exc_i    = 1'b0;
        step_i   = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_pc_en",    pc_en_o,       32'd0);
        check("rst_pc_next",  pc_next_o,     RESET_VECTOR);
        check("rst_req",      imem_req_o,    32'd0);
        check("rst_valid",    fetch_valid_o, 32'd0);
        check("rst_epc",      epc_o,         32'd0);
        check("rst_epc_we",   epc_we_o,      32'd0);
        check("rst_halted",   halted_o,      32'd0);
    endtask

    // One clock: compare on the falling edge, advance the model on the
    // rising edge, return 1 ns later ready for new inputs.
    task automatic cycle();
        int          rank;
        logic [31:0] tgt;
        logic [31:0] nxt;
        bit          done;
        bit          en;
        bit          valid;

        @(negedge clk);
        // Best redirect: pending first, then same-cycle pulses in rising
        // priority; a newcomer of equal or higher rank takes over.
        rank = m_pend_rank;
        tgt  = m_pend_tgt;
        if (branch_i && rank <= 1) begin rank = 1; tgt = branch_target_i; end
        if (jump_i   && rank <= 2) begin rank = 2; tgt = jump_target_i;   end
        if (exc_i    && rank <= 3) begin rank = 3; tgt = EXC_VECTOR;      end

        done  = (m_mode == MODE_FETCH) && imem_ack_i;
        en    = 1'b0;
        valid = 1'b0;
        nxt   = RESET_VECTOR;
        if (m_mode == MODE_BOOT) begin
            en = 1'b1;
        end else if (done && rank > 0) begin
            en  = 1'b1;
            nxt = tgt;
        end else if (done && !stall_i) begin
            en    = 1'b1;
            valid = 1'b1;
            nxt   = m_pc + 32'd4;
        end

        check("pc_reg",      pc_i,          m_pc);
        check("imem_req",    imem_req_o,    {31'd0, m_mode == MODE_FETCH});
        check("halted",      halted_o,      {31'd0, m_mode == MODE_HALT});
        check("pc_en",       pc_en_o,       {31'd0, en});
        check("fetch_valid", fetch_valid_o, {31'd0, valid});
        check("epc",         epc_o,         m_epc);
        check("epc_we",      epc_we_o,      {31'd0, m_epc_we});
        if (en) check("pc_next", pc_next_o, nxt);

        @(posedge clk);
        if (en) m_pc = nxt;
        if (done) begin
            m_pend_rank = 0;
        end else if (rank > 0) begin
            m_pend_rank = rank;
            m_pend_tgt  = tgt;
        end
        m_epc_we = exc_i;
        if (exc_i) m_epc = exc_pc_i;
        case (m_mode)
            MODE_BOOT:  m_mode = MODE_FETCH;
            MODE_FETCH: if (done && halt_i) m_mode = MODE_HALT;
            default:    if (step_i || !halt_i) m_mode = MODE_FETCH;
        endcase
        #1;
    endtask

    task automatic run(input logic ack, input logic stall);
        imem_ack_i = ack;
        stall_i    = stall;
        cycle();
        clear_pulses();
    endtask

    initial begin
        rst_n           = 1'b0;
        imem_ack_i      = 1'b0;
        stall_i         = 1'b0;
        halt_i          = 1'b0;
        branch_target_i = 32'h0;
        jump_target_i   = 32'h0;
        exc_pc_i        = 32'h0;
        clear_pulses();
        model_reset();

        // Reset state, then release 1 ns after a rising edge
        #12;
        check_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // BOOT then zero-wait fetches 0x0, 0x4, 0x8, 0xC
        repeat (5) run(1'b1, 1'b0);

        // Wait three cycles at 0x10, branch to 0x40 latched in wait cycle 1
        run(1'b0, 1'b0);
        branch_i = 1'b1; branch_target_i = 32'h40;
        run(1'b0, 1'b0);
        run(1'b0, 1'b0);
        run(1'b1, 1'b0);
        check("redirect_pc", pc_i, 32'h40);
        run(1'b1, 1'b0);

        // Exception, jump and branch in the same cycle
        exc_i  = 1'b1; exc_pc_i = 32'h20;
        jump_i = 1'b1; jump_target_i = 32'h200;
        branch_i = 1'b1; branch_target_i = 32'h300;
        run(1'b1, 1'b0);
        check("exc_vector_pc", pc_i, 32'h80);
        run(1'b1, 1'b0);

        // Two stalled completions, then advance
        run(1'b1, 1'b1);
        run(1'b1, 1'b1);
        run(1'b1, 1'b0);

        // Jump overrides a stall; jump to the top word then wrap to 0
        jump_i = 1'b1; jump_target_i = 32'hFFFF_FFFC;
        run(1'b1, 1'b1);
        run(1'b1, 1'b0);
        check("wrap_pc", pc_i, 32'h0);
        run(1'b1, 1'b0);

        // Debug halt, single step, redirect latched while halted
        halt_i = 1'b1;
        run(1'b1, 1'b0);
        run(1'b1, 1'b0);
        step_i = 1'b1;
        run(1'b1, 1'b0);
        run(1'b1, 1'b0);
        run(1'b1, 1'b0);
        branch_i = 1'b1; branch_target_i = 32'h500;
        run(1'b1, 1'b0);
        halt_i = 1'b0;
        run(1'b1, 1'b0);
        run(1'b1, 1'b0);
        check("halt_branch_pc", pc_i, 32'h500);

        // Reset while waiting for ack with a pending jump
        run(1'b0, 1'b0);
        jump_i = 1'b1; jump_target_i = 32'h700;
        run(1'b0, 1'b0);
        run(1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) run(1'b1, 1'b0);
        check("post_reset_pc", pc_i, 32'h8);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            imem_ack_i      = ($urandom_range(3) != 0);
            stall_i         = ($urandom_range(4) == 0);
            branch_i        = ($urandom_range(9) == 0);
            branch_target_i = rnd_addr();
            jump_i          = ($urandom_range(13) == 0);
            jump_target_i   = rnd_addr();
            exc_i           = ($urandom_range(24) == 0);
            exc_pc_i        = rnd_addr();
            step_i          = ($urandom_range(7) == 0);
            if ($urandom_range(11) == 0) halt_i = !halt_i;
            cycle();
            clear_pulses();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that sequences the program-counter register of the MIPS core. It drives the PC register's load enable and next-address input, and issues instruction-memory requests with a req/ack handshake. It selects the next PC by priority among exception vector, jump, branch and sequential, and supports hazard stalls and a debug halt/single-step mode. It sits between the hazard/branch logic of the pipeline and the PC register feeding instruction memory.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- EXC_VECTOR, 32'h0000_0080, exception handler address
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- pc_i  in  32  current PC (PC register output)
- pc_next_o  out  32  next PC (PC register input)
- pc_en_o  out  1  PC register load enable
- imem_req_o  out  1  fetch request; address is pc_i
- imem_ack_i  in  1  instruction memory done this cycle
- fetch_valid_o  out  1  fetched word valid for decode this cycle
- stall_i  in  1  hazard unit: hold PC, refetch
- branch_i / branch_target_i  in  1/32  taken branch redirect
- jump_i / jump_target_i  in  1/32  jump redirect
- exc_i / exc_pc_i  in  1/32  exception and faulting PC
- epc_o  out  32  saved exception PC; epc_we_o out 1 one-cycle write pulse
- halt_i  in  1  debug halt level; step_i in 1 single-step pulse
- halted_o  out  1  high in HALT

## Operation
- States: BOOT, FETCH, HALT.
- BOOT (entered on reset): pc_en_o=1, pc_next_o=RESET_VECTOR for one cycle, then FETCH.
- FETCH: imem_req_o=1 held until imem_ack_i. Completion = imem_ack_i high.
- Next-PC priority (sub-module): exc > jump > branch > pc_i+4 (32-bit, wraps at 2^32 silently).
- Redirects (exc_i/jump_i/branch_i) are single-cycle pulses. A redirect arriving while no completion occurs is latched in a one-entry pending register; a later redirect replaces it only if of equal or higher priority. Pending and same-cycle redirects are merged by priority.
- On completion with a redirect (pending or same-cycle): pc_en_o=1, pc_next_o=redirect target, fetch_valid_o=0 (squash), pending cleared.
- On completion, no redirect, stall_i=0: pc_en_o=1, pc_next_o=pc_i+4, fetch_valid_o=1.
- On completion with stall_i=1 and no redirect: pc_en_o=0, fetch_valid_o=0, refetch same address. A redirect overrides a stall.
- Exception: the cycle exc_i is taken, epc_o<=exc_pc_i and epc_we_o pulses next cycle; target EXC_VECTOR.
- halt_i high at a completion: that completion is processed normally, then HALT. In HALT: imem_req_o=0, pc_en_o=0. Redirects are still latched. step_i pulse -> FETCH for exactly one completion, then back to HALT if halt_i is still high. halt_i low -> FETCH.
- rst_n low mid-operation: immediate return to BOOT, pending cleared, request dropped.

## Timing
- Reset values: pc_en_o=0, pc_next_o=RESET_VECTOR, imem_req_o=0, fetch_valid_o=0, epc_o=0, epc_we_o=0, halted_o=0, state=BOOT.
- pc_en_o, pc_next_o and fetch_valid_o are combinational from state, imem_ack_i, stall_i, redirects and the pending register. imem_req_o and halted_o are decoded from state only.
- Zero-wait memory (ack in same cycle as req): one instruction per clock.
- First request: cycle after BOOT, address RESET_VECTOR.
- Redirect to fetch at new address: next cycle after the completion that applies it.

## Structure
- Shared mips_pkg: state enum, next-PC source encoding (SRC_SEQ/BR/JMP/EXC), default RESET_VECTOR/EXC_VECTOR constants.
- Sub-module next_pc_mux: pure priority select of source and target. All state and pending logic stays in pc_sequencer.

## Test plan
- Reset release, ack always high -> BOOT loads 0x0, then fetches 0x0, 0x4, 0x8 with fetch_valid_o=1 each cycle.
- Ack delayed 3 cycles at PC 0x10, branch_i to 0x40 in wait cycle 1 -> at ack: pc_next_o=0x40, fetch_valid_o=0, next request at 0x40.
- Same-cycle exc_i (exc_pc_i=0x20), jump_i and branch_i -> pc_next_o=0x80, epc_o=0x20, epc_we_o pulses once.
- stall_i high for 2 completions at 0x30 -> pc_en_o=0 twice, 0x30 refetched, then advances to 0x34.
- halt_i asserted at 0x50 -> HALT after 0x50 completes; step_i -> exactly one fetch (0x54), halted_o re-asserts.
- rst_n pulsed low while waiting for ack with a pending jump -> outputs return to reset values, first fetch at 0x0, jump discarded.
